inst_fetch_seq: RTL and testbench

Instruction fetch sequencer: the consumer side of the fetch-control interface. It owns the program counter, drives a synchronous instruction memory, and delivers instruction/PC pairs to decode. It obeys hold, jump, interrupt-vector and wait requests from decode, hazard control, branch/ALU and the interrupt scheduler. It sits between imem and the decode stage of the core.

---
 rtl/inst_fetch_seq_pkg.sv | 21 ++
 rtl/fetch_skid_buf.sv | 56 +++++
 rtl/inst_fetch_seq.sv | 169 ++++++++++++++++
 tb/tb_inst_fetch_seq.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/inst_fetch_seq_pkg.sv
// Shared types for the instruction fetch sequencer.
package inst_fetch_seq_pkg;

  localparam int unsigned InstrW = 32;

  typedef logic [31:0] address_t;

  typedef enum logic [1:0] {
    StBoot,
    StRun,
    StWait
  } fetch_state_e;

  // A fetched instruction together with the address it was read from.
  typedef struct packed {
    logic              valid;
    logic [InstrW-1:0] instr;
    address_t          pc;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_skid_buf.sv
// Single-entry skid buffer that catches imem read data returning while decode holds.
module fetch_skid_buf
  import inst_fetch_seq_pkg::*;
#(
  parameter int unsigned ADDR_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic              drain,
  input  logic              squash,
  input  logic [InstrW-1:0] in_instr,
  input  logic [ADDR_W-1:0] in_pc,
  output logic              valid,
  output logic [InstrW-1:0] instr,
  output logic [ADDR_W-1:0] pc
);

  logic              valid_q, valid_d;
  logic [InstrW-1:0] instr_q, instr_d;
  logic [ADDR_W-1:0] pc_q, pc_d;

  // Squash beats load beats drain; a load replaces any held entry.
  always_comb begin
    valid_d = valid_q;
    instr_d = instr_q;
    pc_d    = pc_q;
    if (squash) begin
      valid_d = 1'b0;
    end else if (load) begin
      valid_d = 1'b1;
      instr_d = in_instr;
      pc_d    = in_pc;
    end else if (drain) begin
      valid_d = 1'b0;
    end
  end

  // Entry storage with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= 1'b0;
      instr_q <= '0;
      pc_q    <= '0;
    end else begin
      valid_q <= valid_d;
      instr_q <= instr_d;
      pc_q    <= pc_d;
    end
  end

  assign valid = valid_q;
  assign instr = instr_q;
  assign pc    = pc_q;

endmodule

// File: rtl/inst_fetch_seq.sv
// Instruction fetch sequencer: owns the PC, drives imem, delivers instr/PC pairs to decode.
module inst_fetch_seq
  import inst_fetch_seq_pkg::*;
#(
  parameter int unsigned       ADDR_W    = 32,
  parameter logic [ADDR_W-1:0] RESET_VEC = '0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] new_pc,
  input  logic              jump,
  input  logic [ADDR_W-1:0] int_vect,
  input  logic              int_jump,
  input  logic              hold,
  input  logic              if_wait,
  input  logic              wake,
  output logic [ADDR_W-1:0] imem_addr,
  output logic              imem_en,
  input  logic [InstrW-1:0] imem_data,
  output logic [InstrW-1:0] ir,
  output logic [ADDR_W-1:0] ir_pc,
  output logic              ir_valid,
  output logic [ADDR_W-1:0] int_ret_pc,
  output logic              waiting
);

  fetch_state_e      state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic              fl_valid_q, fl_valid_d;  // read issued last cycle, data on imem_data now
  logic [ADDR_W-1:0] fl_pc_q, fl_pc_d;
  logic [InstrW-1:0] ir_q, ir_d;
  logic [ADDR_W-1:0] ir_pc_q, ir_pc_d;
  logic              ir_valid_q, ir_valid_d;
  logic [ADDR_W-1:0] int_ret_pc_q, int_ret_pc_d;

  logic              skid_load, skid_drain, skid_squash;
  logic              skid_valid;
  logic [InstrW-1:0] skid_instr;
  logic [ADDR_W-1:0] skid_pc;

  logic              fetch;
  logic [ADDR_W-1:0] resume_pc;

  fetch_skid_buf #(
    .ADDR_W (ADDR_W)
  ) u_skid (
    .clk      (clk),
    .reset    (reset),
    .load     (skid_load),
    .drain    (skid_drain),
    .squash   (skid_squash),
    .in_instr (imem_data),
    .in_pc    (fl_pc_q),
    .valid    (skid_valid),
    .instr    (skid_instr),
    .pc       (skid_pc)
  );

  // Next-state, PC and delivery logic; control inputs are taken in fixed priority order.
  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    fl_valid_d   = 1'b0;
    fl_pc_d      = fl_pc_q;
    ir_d         = ir_q;
    ir_pc_d      = ir_pc_q;
    ir_valid_d   = ir_valid_q;
    int_ret_pc_d = int_ret_pc_q;
    skid_load    = 1'b0;
    skid_drain   = 1'b0;
    skid_squash  = 1'b0;
    fetch        = 1'b0;

    // Oldest instruction not yet handed to decode, ignoring the one currently in ir.
    if (skid_valid) begin
      resume_pc = skid_pc;
    end else if (fl_valid_q) begin
      resume_pc = fl_pc_q;
    end else begin
      resume_pc = pc_q;
    end

    if (int_jump) begin
      // A held ir has not been consumed, so it is where the handler must return to.
      int_ret_pc_d = (ir_valid_q && hold) ? ir_pc_q : resume_pc;
      pc_d         = int_vect;
      skid_squash  = 1'b1;
      ir_valid_d   = 1'b0;
      state_d      = StRun;
    end else if (jump) begin
      pc_d        = new_pc;
      skid_squash = 1'b1;
      ir_valid_d  = 1'b0;
      if (state_q != StWait) begin
        state_d = StRun;
      end
    end else if (hold) begin
      // No new read is issued, so at most the one outstanding word needs parking.
      skid_load = fl_valid_q;
    end else if (if_wait) begin
      pc_d        = resume_pc;
      skid_squash = 1'b1;
      ir_valid_d  = 1'b0;
      state_d     = StWait;
    end else begin
      case (state_q)
        StWait: begin
          if (wake) begin
            state_d = StBoot;
          end
        end
        StBoot, StRun: begin
          fetch      = 1'b1;
          pc_d       = pc_q + ADDR_W'(1);
          fl_valid_d = 1'b1;
          fl_pc_d    = pc_q;
          state_d    = StRun;
        end
        default: state_d = StBoot;
      endcase

      // The skid entry is older than anything in flight, so it goes first.
      if (skid_valid) begin
        ir_d       = skid_instr;
        ir_pc_d    = skid_pc;
        ir_valid_d = 1'b1;
        skid_drain = 1'b1;
      end else if (fl_valid_q) begin
        ir_d       = imem_data;
        ir_pc_d    = fl_pc_q;
        ir_valid_d = 1'b1;
      end else begin
        ir_valid_d = 1'b0;
      end
    end
  end

  // State, PC, in-flight tag and decode-facing registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= StBoot;
      pc_q         <= RESET_VEC;
      fl_valid_q   <= 1'b0;
      fl_pc_q      <= '0;
      ir_q         <= '0;
      ir_pc_q      <= '0;
      ir_valid_q   <= 1'b0;
      int_ret_pc_q <= '0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      fl_valid_q   <= fl_valid_d;
      fl_pc_q      <= fl_pc_d;
      ir_q         <= ir_d;
      ir_pc_q      <= ir_pc_d;
      ir_valid_q   <= ir_valid_d;
      int_ret_pc_q <= int_ret_pc_d;
    end
  end

  assign imem_addr  = pc_q;
  assign imem_en    = fetch && !reset;
  assign ir         = ir_q;
  assign ir_pc      = ir_pc_q;
  assign ir_valid   = ir_valid_q;
  assign int_ret_pc = int_ret_pc_q;
  assign waiting    = (state_q == StWait);

endmodule

// File: tb/tb_inst_fetch_seq.sv
// Directed bench for inst_fetch_seq with an imem model and an in-order delivery scoreboard.
module tb_inst_fetch_seq;

  localparam logic [31:0] RV  = 32'h100;
  localparam logic [31:0] KEY = 32'h0000_A5A5;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] new_pc;
  logic        jump;
  logic [31:0] int_vect;
  logic        int_jump;
  logic        hold;
  logic        if_wait;
  logic        wake;
  logic [31:0] imem_addr;
  logic        imem_en;
  logic [31:0] imem_data = 32'h0;
  logic [31:0] ir;
  logic [31:0] ir_pc;
  logic        ir_valid;
  logic [31:0] int_ret_pc;
  logic        waiting;

  int n_tests = 0;
  int n_fail  = 0;
  logic [31:0] exp_q[$];

  inst_fetch_seq #(
    .ADDR_W    (32),
    .RESET_VEC (RV)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .new_pc     (new_pc),
    .jump       (jump),
    .int_vect   (int_vect),
    .int_jump   (int_jump),
    .hold       (hold),
    .if_wait    (if_wait),
    .wake       (wake),
    .imem_addr  (imem_addr),
    .imem_en    (imem_en),
    .imem_data  (imem_data),
    .ir         (ir),
    .ir_pc      (ir_pc),
    .ir_valid   (ir_valid),
    .int_ret_pc (int_ret_pc),
    .waiting    (waiting)
  );

  always #5 clk = ~clk;

  // Synchronous imem: data one cycle after the strobe, junk when not read.
  always @(posedge clk) begin
    if (imem_en) imem_data <= imem_addr ^ KEY;
    else         imem_data <= 32'hDEAD_BEEF;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout, required finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_tests++;
    assert (got === want) else begin
      n_fail++;
      $error("FAIL %s: observed %h, expected %h", tag, got, want);
    end
  endtask

  task automatic push_run(input logic [31:0] start, input int n);
    for (int i = 0; i < n; i++) exp_q.push_back(start + 32'(i));
  endtask

  // Mid-cycle sample; an ir seen with hold low is consumed by decode.
  task automatic half();
    logic [31:0] want;
    @(negedge clk);
    if (ir_valid && !hold) begin
      n_tests++;
      assert (exp_q.size() > 0) else begin
        n_fail++;
        $error("FAIL delivery_unexpected: observed ir_pc %h, expected none", ir_pc);
      end
      if (exp_q.size() > 0) begin
        want = exp_q.pop_front();
        check("deliver_pc", ir_pc, want);
        check("deliver_ir", ir, want ^ KEY);
      end
    end
  endtask

  task automatic next();
    @(posedge clk);
    #1;
  endtask

  task automatic tick();
    half();
    next();
  endtask

  initial begin
    reset = 1'b1; new_pc = '0; jump = 1'b0; int_vect = '0; int_jump = 1'b0;
    hold = 1'b0; if_wait = 1'b0; wake = 1'b0;
    repeat (2) tick();
    half(); check("en_in_reset", 32'(imem_en), 32'd0); next();

    // Reset then run from RESET_VEC.
    reset = 1'b0;
    push_run(32'h100, 13);
    half();
    check("rst_ir_valid", 32'(ir_valid), 32'd0);
    check("rst_ir", ir, 32'd0);
    check("rst_ir_pc", ir_pc, 32'd0);
    check("rst_ret_pc", int_ret_pc, 32'd0);
    check("rst_waiting", 32'(waiting), 32'd0);
    check("boot_addr", imem_addr, RV);
    check("boot_en", 32'(imem_en), 32'd1);
    next();
    half(); check("boot_lat", 32'(ir_valid), 32'd0); next();
    repeat (12) tick();

    // Hold while streaming at 0x200.
    jump = 1'b1; new_pc = 32'h200; tick(); jump = 1'b0;
    push_run(32'h200, 4);
    half();
    check("jmp_bubble0", 32'(ir_valid), 32'd0);
    check("jmp_fetch_addr", imem_addr, 32'h200);
    check("jmp_fetch_en", 32'(imem_en), 32'd1);
    next();
    half(); check("jmp_bubble1", 32'(ir_valid), 32'd0); next();
    hold = 1'b1;
    for (int i = 0; i < 3; i++) begin
      half();
      check("hold_valid", 32'(ir_valid), 32'd1);
      check("hold_ir_pc", ir_pc, 32'h200);
      check("hold_en", 32'(imem_en), 32'd0);
      next();
    end
    hold = 1'b0;
    repeat (4) tick();

    // Jump while held.
    hold = 1'b1; jump = 1'b1; new_pc = 32'h40;
    half(); check("jmp_hold_en", 32'(imem_en), 32'd0); next();
    hold = 1'b0; jump = 1'b0;
    push_run(32'h40, 2);
    for (int i = 0; i < 2; i++) begin
      half(); check("jmp_hold_bubble", 32'(ir_valid), 32'd0); next();
    end
    tick();

    // Interrupt with 0x123 in flight.
    jump = 1'b1; new_pc = 32'h120; tick(); jump = 1'b0;
    push_run(32'h120, 3);
    repeat (4) tick();
    int_jump = 1'b1; int_vect = 32'h800; tick(); int_jump = 1'b0;
    push_run(32'h800, 1);
    half();
    check("int_ret_pc", int_ret_pc, 32'h123);
    check("int_bubble0", 32'(ir_valid), 32'd0);
    next();
    half(); check("int_bubble1", 32'(ir_valid), 32'd0); next();

    // Wait with 0x50 next to deliver, wake ten cycles later.
    jump = 1'b1; new_pc = 32'h4C; tick(); jump = 1'b0;
    push_run(32'h4C, 4);
    repeat (5) tick();
    if_wait = 1'b1; tick(); if_wait = 1'b0;
    for (int i = 0; i < 10; i++) begin
      wake = (i == 9);
      half();
      check("wait_waiting", 32'(waiting), 32'd1);
      check("wait_en", 32'(imem_en), 32'd0);
      check("wait_ir_valid", 32'(ir_valid), 32'd0);
      next();
    end
    wake = 1'b0;
    push_run(32'h50, 3);
    half();
    check("wake_waiting", 32'(waiting), 32'd0);
    check("wake_en", 32'(imem_en), 32'd1);
    check("wake_addr", imem_addr, 32'h50);
    next();
    repeat (3) tick();

    // Interrupt out of WAIT.
    if_wait = 1'b1; tick(); if_wait = 1'b0;
    repeat (2) tick();
    int_jump = 1'b1; int_vect = 32'h900;
    half(); check("intw_waiting", 32'(waiting), 32'd1); next();
    int_jump = 1'b0;
    push_run(32'h900, 1);
    half();
    check("intw_ret_pc", int_ret_pc, 32'h53);
    check("intw_waiting_off", 32'(waiting), 32'd0);
    check("intw_en", 32'(imem_en), 32'd1);
    check("intw_addr", imem_addr, 32'h900);
    next();
    tick();

    // Wrap past the top of the address space; wake outside WAIT is ignored.
    jump = 1'b1; new_pc = 32'hFFFF_FFFE; tick(); jump = 1'b0;
    exp_q.push_back(32'hFFFF_FFFE);
    exp_q.push_back(32'hFFFF_FFFF);
    push_run(32'h0, 2);
    wake = 1'b1;
    repeat (5) tick();
    wake = 1'b0;

    // Reset wins over a simultaneous jump.
    reset = 1'b1; jump = 1'b1; new_pc = 32'h777; tick(); reset = 1'b0; jump = 1'b0;
    push_run(32'h100, 2);
    half();
    check("rst2_addr", imem_addr, RV);
    check("rst2_en", 32'(imem_en), 32'd1);
    check("rst2_ir_valid", 32'(ir_valid), 32'd0);
    check("rst2_ret_pc", int_ret_pc, 32'd0);
    next();
    repeat (3) tick();

    // Interrupt while decode holds: the held ir is the return point.
    hold = 1'b1; int_jump = 1'b1; int_vect = 32'hA00; tick();
    hold = 1'b0; int_jump = 1'b0;
    half();
    check("inth_ret_pc", int_ret_pc, 32'h102);
    check("inth_bubble", 32'(ir_valid), 32'd0);
    check("sb_empty", 32'(exp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
